// File: rtl/sd_data_phys.sv
// SD host DAT0 physical layer: serializes TX FIFO words for block writes and
// deserializes block reads, framing each block with start bit, CRC16 and end bit.
module sd_data_phys #(
    parameter int WORDS = 128
) (
    input  logic        SD_clock,
    input  logic        Reset,
    input  logic        Send,
    input  logic        Idle,
    input  logic        WriteRead,
    input  logic [31:0] Data_from_FIFO,
    output logic        FIFO_read,
    output logic [31:0] Data_to_FIFO,
    output logic        FIFO_write,
    input  logic        Data_pin_in,
    output logic        Data_pin_out,
    output logic        Data_pin_oe,
    output logic        Serial_ready,
    output logic        Complete,
    output logic        Crc_error
);

    typedef enum logic [3:0] {
        IDLE,
        WR_START,
        WR_DATA,
        WR_CRC,
        WR_END,
        WR_BUSY,
        RD_WAIT,
        RD_DATA,
        RD_CRC,
        RD_END,
        DONE
    } state_t;

    localparam logic [7:0] LAST_WORD = 8'(WORDS - 1);

    state_t      state;
    state_t      next_state;
    logic [31:0] shift_reg;
    logic [15:0] crc;
    logic [4:0]  bit_cnt;
    logic [7:0]  word_cnt;
    logic [3:0]  crc_cnt;
    logic        settle;
    logic        pin_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc_in, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc_in[15];
        return {crc_in[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge SD_clock) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so every path assigns next_state and no latch is inferred.
        next_state = state;
        if (Idle) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     if (Send) next_state = WriteRead ? WR_START : RD_WAIT;
                WR_START: next_state = WR_DATA;
                WR_DATA:  if (bit_cnt == 5'd31 && word_cnt == LAST_WORD) next_state = WR_CRC;
                WR_CRC:   if (crc_cnt == 4'd15) next_state = WR_END;
                WR_END:   next_state = WR_BUSY;
                // The first busy sample would still see our own end bit, so it is skipped.
                WR_BUSY:  if (settle && pin_q) next_state = DONE;
                RD_WAIT:  if (!Data_pin_in) next_state = RD_DATA;
                RD_DATA:  if (bit_cnt == 5'd31 && word_cnt == LAST_WORD) next_state = RD_CRC;
                RD_CRC:   if (crc_cnt == 4'd15) next_state = RD_END;
                RD_END:   if (settle) next_state = DONE;
                DONE:     next_state = IDLE;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        Data_pin_out = 1'b1;
        Data_pin_oe  = 1'b0;
        Serial_ready = 1'b0;
        Complete     = 1'b0;
        case (state)
            IDLE:     Serial_ready = 1'b1;
            WR_START: begin
                Data_pin_oe  = 1'b1;
                Data_pin_out = 1'b0;
            end
            WR_DATA:  begin
                Data_pin_oe  = 1'b1;
                Data_pin_out = shift_reg[31];
            end
            WR_CRC:   begin
                Data_pin_oe  = 1'b1;
                Data_pin_out = crc[15];
            end
            WR_END:   Data_pin_oe = 1'b1;
            DONE:     Complete = 1'b1;
            default:  ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge SD_clock) begin
        if (Reset) begin
            shift_reg    <= '0;
            crc          <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            crc_cnt      <= '0;
            settle       <= 1'b0;
            pin_q        <= 1'b1;
            FIFO_read    <= 1'b0;
            FIFO_write   <= 1'b0;
            Data_to_FIFO <= '0;
            Crc_error    <= 1'b0;
        end else begin
            FIFO_read  <= 1'b0;
            FIFO_write <= 1'b0;
            pin_q      <= Data_pin_in;
            if (Idle) begin
                crc      <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
                crc_cnt  <= '0;
                settle   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (Send) begin
                        Crc_error <= 1'b0;
                        crc       <= '0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        crc_cnt   <= '0;
                        settle    <= 1'b0;
                    end
                    WR_START: begin
                        shift_reg <= Data_from_FIFO;
                        FIFO_read <= 1'b1;
                    end
                    WR_DATA: begin
                        crc     <= crc16_step(crc, shift_reg[31]);
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            if (word_cnt != LAST_WORD) begin
                                shift_reg <= Data_from_FIFO;
                                FIFO_read <= 1'b1;
                                word_cnt  <= word_cnt + 8'd1;
                            end
                        end else begin
                            shift_reg <= {shift_reg[30:0], 1'b0};
                        end
                    end
                    WR_CRC: begin
                        crc     <= {crc[14:0], 1'b0};
                        crc_cnt <= crc_cnt + 4'd1;
                    end
                    WR_BUSY: settle <= 1'b1;
                    RD_DATA: begin
                        shift_reg <= {shift_reg[30:0], Data_pin_in};
                        crc       <= crc16_step(crc, Data_pin_in);
                        bit_cnt   <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            Data_to_FIFO <= {shift_reg[30:0], Data_pin_in};
                            FIFO_write   <= 1'b1;
                            word_cnt     <= word_cnt + 8'd1;
                        end
                    end
                    RD_CRC: begin
                        shift_reg <= {shift_reg[30:0], Data_pin_in};
                        crc_cnt   <= crc_cnt + 4'd1;
                    end
                    RD_END: begin
                        settle <= 1'b1;
                        // Received CRC sits in the low half of the shift register, end bit in pin_q.
                        if (settle) Crc_error <= (shift_reg[15:0] != crc) || !pin_q;
                    end
                    DONE: settle <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_data_phys.sv
// Directed bench for sd_data_phys: one instance with a single-word block for
// write/read/abort/reset cases and one with a two-word block for the busy case.
module tb_sd_data_phys;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic idle;
    logic write_read;
    logic pin_in;

    logic        a_send;
    logic [31:0] a_tx;
    logic        a_fifo_read;
    logic [31:0] a_data_to_fifo;
    logic        a_fifo_write;
    logic        a_pin_out;
    logic        a_pin_oe;
    logic        a_ready;
    logic        a_complete;
    logic        a_crc_error;

    logic        b_send;
    logic [31:0] b_tx;
    logic        b_fifo_read;
    logic [31:0] b_data_to_fifo;
    logic        b_fifo_write;
    logic        b_pin_out;
    logic        b_pin_oe;
    logic        b_ready;
    logic        b_complete;
    logic        b_crc_error;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] b_words [2] = '{32'h0000_0000, 32'h0000_0001};
    int b_idx;
    assign b_tx = (b_idx < 2) ? b_words[b_idx] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst)              b_idx <= 0;
        else if (b_fifo_read) b_idx <= b_idx + 1;
    end

    sd_data_phys #(.WORDS(1)) dut_a (
        .SD_clock       (clk),
        .Reset          (rst),
        .Send           (a_send),
        .Idle           (idle),
        .WriteRead      (write_read),
        .Data_from_FIFO (a_tx),
        .FIFO_read      (a_fifo_read),
        .Data_to_FIFO   (a_data_to_fifo),
        .FIFO_write     (a_fifo_write),
        .Data_pin_in    (pin_in),
        .Data_pin_out   (a_pin_out),
        .Data_pin_oe    (a_pin_oe),
        .Serial_ready   (a_ready),
        .Complete       (a_complete),
        .Crc_error      (a_crc_error)
    );

    sd_data_phys #(.WORDS(2)) dut_b (
        .SD_clock       (clk),
        .Reset          (rst),
        .Send           (b_send),
        .Idle           (idle),
        .WriteRead      (write_read),
        .Data_from_FIFO (b_tx),
        .FIFO_read      (b_fifo_read),
        .Data_to_FIFO   (b_data_to_fifo),
        .FIFO_write     (b_fifo_write),
        .Data_pin_in    (pin_in),
        .Data_pin_out   (b_pin_out),
        .Data_pin_oe    (b_pin_oe),
        .Serial_ready   (b_ready),
        .Complete       (b_complete),
        .Crc_error      (b_crc_error)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Full single-word write on instance A; call at a negedge. Cycle n = n-th cycle after the Send edge.
    task automatic a_write(output logic [49:0] line, output logic [49:0] oe, output int reads,
                           output int done_cyc, output int completes, output int ready_cyc);
        line = '0; oe = '0; reads = 0; done_cyc = -1; completes = 0; ready_cyc = -1;
        write_read = 1'b1;
        pin_in     = 1'b1;
        a_send     = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 0) a_send = 1'b0;
            if (n < 50) begin
                line[49-n] = a_pin_out;
                oe[49-n]   = a_pin_oe;
            end
            if (a_fifo_read) reads++;
            if (a_complete) begin
                completes++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (a_ready && ready_cyc < 0) ready_cyc = n;
        end
    endtask

    // Single-word read on instance A: five idle-line cycles, start, data, CRC, end bit.
    task automatic a_read(input logic [31:0] word, input logic [15:0] crc, input logic end_bit,
                          output logic [31:0] rx, output int writes, output int wr_cyc,
                          output int done_cyc, output logic err, output logic err_at_start);
        logic [54:0] bits;
        bits = {5'b11111, 1'b0, word, crc, end_bit};
        rx = '0; writes = 0; wr_cyc = -1; done_cyc = -1; err = 1'b0; err_at_start = 1'b0;
        write_read = 1'b0;
        pin_in     = 1'b1;
        a_send     = 1'b1;
        for (int j = 0; j < 70; j++) begin
            @(negedge clk);
            if (j == 0) begin
                a_send       = 1'b0;
                err_at_start = a_crc_error;
            end
            if (a_fifo_write) begin
                writes++;
                rx = a_data_to_fifo;
                if (wr_cyc < 0) wr_cyc = j;
            end
            if (a_complete && done_cyc < 0) begin
                done_cyc = j;
                err      = a_crc_error;
            end
            pin_in = (j < 55) ? bits[54-j] : 1'b1;
        end
    endtask

    initial begin
        logic [49:0] line;
        logic [49:0] oe;
        logic [81:0] b_line;
        logic [31:0] rx;
        logic        err;
        logic        err0;
        int          reads, writes, wr_cyc, done_cyc, completes, ready_cyc;
        int          rd_first, rd_second, oe_high, ready_low;

        rst = 1'b1; idle = 1'b0; write_read = 1'b1; pin_in = 1'b1;
        a_send = 1'b0; a_tx = 32'h0000_0000; b_send = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_pin_out", a_pin_out, 1'b1);
        check("rst_oe_ready_complete", {a_pin_oe, a_ready, a_complete}, 3'b010);
        check("rst_strobes_err", {a_fifo_read, a_fifo_write, a_crc_error}, 3'b000);
        check("rst_data_to_fifo", a_data_to_fifo, 32'h0);

        // Zero write, one word.
        a_write(line, oe, reads, done_cyc, completes, ready_cyc);
        check("zw_line", line, {1'b0, 32'h0, 16'h0000, 1'b1});
        check("zw_oe", oe, {50{1'b1}});
        check("zw_reads", reads, 1);
        check("zw_complete_cycle", done_cyc, 52);
        check("zw_complete_count", completes, 1);
        check("zw_ready_cycle", ready_cyc, 53);

        // Two-word write 0x0, 0x1 with the card holding busy for 10 cycles.
        write_read = 1'b1; pin_in = 1'b1;
        b_line = '0; reads = 0; rd_first = -1; rd_second = -1; done_cyc = -1; completes = 0;
        b_send = 1'b1;
        for (int n = 0; n < 110; n++) begin
            @(negedge clk);
            if (n == 0) b_send = 1'b0;
            if (n < 82) b_line[81-n] = b_pin_out;
            if (b_fifo_read) begin
                reads++;
                if (rd_first < 0) rd_first = n;
                else if (rd_second < 0) rd_second = n;
            end
            if (b_complete) begin
                completes++;
                if (done_cyc < 0) done_cyc = n;
            end
            pin_in = (n >= 82 && n < 92) ? 1'b0 : 1'b1;
        end
        check("nzw_line", b_line, {1'b0, 32'h0, 32'h1, 16'h1021, 1'b1});
        check("nzw_reads", reads, 2);
        check("nzw_read_gap", rd_second - rd_first, 32);
        check("nzw_first_read_cycle", rd_first, 1);
        check("nzw_complete_cycle", done_cyc, 94);
        check("nzw_complete_count", completes, 1);

        // Reads: good CRC, bad CRC, bad end bit.
        a_read(32'h0000_0001, 16'h1021, 1'b1, rx, writes, wr_cyc, done_cyc, err, err0);
        check("rd_ok_data", rx, 32'h0000_0001);
        check("rd_ok_writes", writes, 1);
        check("rd_ok_write_cycle", wr_cyc, 38);
        check("rd_ok_complete_cycle", done_cyc, 56);
        check("rd_ok_crc_error", err, 1'b0);

        a_read(32'h0000_0001, 16'h1020, 1'b1, rx, writes, wr_cyc, done_cyc, err, err0);
        check("rd_badcrc_complete_cycle", done_cyc, 56);
        check("rd_badcrc_crc_error", err, 1'b1);

        a_read(32'h0000_0001, 16'h1021, 1'b0, rx, writes, wr_cyc, done_cyc, err, err0);
        check("rd_badend_err_cleared_on_send", err0, 1'b0);
        check("rd_badend_complete_cycle", done_cyc, 56);
        check("rd_badend_crc_error", err, 1'b1);

        // Abort at the 10th write data bit, then a clean restart.
        write_read = 1'b1; pin_in = 1'b1; completes = 0;
        a_send = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (n == 0) a_send = 1'b0;
            if (a_complete) completes++;
            if (n == 10) idle = 1'b1;
            if (n == 11) begin
                check("abort_pin", {a_pin_oe, a_pin_out}, 2'b01);
                check("abort_ready", a_ready, 1'b1);
                idle = 1'b0;
            end
        end
        check("abort_no_complete", completes, 0);
        a_write(line, oe, reads, done_cyc, completes, ready_cyc);
        check("restart_line", line, {1'b0, 32'h0, 16'h0000, 1'b1});
        check("restart_complete_cycle", done_cyc, 52);

        // Send together with Idle while in IDLE.
        oe_high = 0; ready_low = 0; reads = 0;
        a_send = 1'b1; idle = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (n == 0) begin a_send = 1'b0; idle = 1'b0; end
            if (a_pin_oe) oe_high++;
            if (!a_ready) ready_low++;
            if (a_fifo_read) reads++;
        end
        check("send_idle_oe", oe_high, 0);
        check("send_idle_ready", ready_low, 0);
        check("send_idle_reads", reads, 0);

        // Reset for two edges mid-data.
        a_send = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (n == 0) a_send = 1'b0;
        end
        check("pre_reset_oe", a_pin_oe, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("mid_reset_pin", {a_pin_oe, a_pin_out}, 2'b01);
        check("mid_reset_ready_complete", {a_ready, a_complete}, 2'b10);
        check("mid_reset_strobes_err", {a_fifo_read, a_fifo_write, a_crc_error}, 3'b000);
        check("mid_reset_data_to_fifo", a_data_to_fifo, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sd_data_phys.md
# sd_data_phys

Physical-layer engine for the SD host DATA path. It sits directly downstream of the DATA control block. On `Send` it serializes FIFO words onto DAT0 (write) or deserializes DAT0 into FIFO words (read). Framing is start bit, data MSB first, CRC16 and end bit. It reports `Serial_ready` / `Complete` back to the control block and honours its `Idle` abort.

## Interface
- `WORDS`, 128: 32-bit words per block (512 bytes); legal range 1..255.
- `SD_clock`  in  1  bit clock; all state on rising edge.
- `Reset`  in  1  one clock; reset is synchronous and active-high.
- `Send`  in  1  start one block transfer; sampled only in IDLE.
- `Idle`  in  1  abort; forces IDLE.
- `WriteRead`  in  1  1 = write (host→card), 0 = read; latched when `Send` is accepted.
- `Data_from_FIFO`  in  32  show-ahead TX FIFO head word.
- `FIFO_read`  out  1  TX FIFO pop strobe, one cycle per word.
- `Data_to_FIFO`  out  32  received word.
- `FIFO_write`  out  1  RX FIFO push strobe, one cycle per word.
- `Data_pin_in`  in  1  DAT0 sampled from card.
- `Data_pin_out`  out  1  DAT0 drive value.
- `Data_pin_oe`  out  1  DAT0 output enable (1 = host drives).
- `Serial_ready`  out  1  high only in IDLE.
- `Complete`  out  1  one-cycle pulse at successful block end.
- `Crc_error`  out  1  read CRC/end-bit failure; valid with `Complete`.

## Operation
- States: IDLE, WR_START, WR_DATA, WR_CRC, WR_END, WR_BUSY, RD_WAIT, RD_DATA, RD_CRC, RD_END, DONE.
- Priority every edge: `Reset` > `Idle` > normal flow. `Idle` or `Reset` from any state:
  - next state IDLE, `Data_pin_oe`=0, `Data_pin_out`=1;
  - strobes 0, no `Complete`;
  - CRC and counters cleared.
- IDLE + `Send` (and `Idle`=0): latch `WriteRead`; clear `Crc_error`; go WR_START or RD_WAIT.
- CRC: CRC16-CCITT (x^16+x^12+x^5+1), init 0x0000, fed with data bits in line order (not start bit).
  - Per-bit update: fb = bit ^ crc[15]; crc = (crc<<1) ^ (fb ? 0x1021 : 0).
- Write path:
  - WR_START drives 0 for one cycle.
  - WR_DATA drives 32·`WORDS` bits, each word MSB first.
  - WR_CRC drives 16 bits, MSB first.
  - WR_END drives 1 for one cycle.
  - WR_BUSY: `Data_pin_oe`=0; wait for `Data_pin_in`=1, sampled from the 2nd WR_BUSY cycle on; then DONE.
- Read path:
  - RD_WAIT waits, unbounded, for `Data_pin_in`=0. Timeout is owned by the control block, which issues `Idle`.
  - RD_DATA samples 32·`WORDS` bits.
  - RD_CRC samples 16 bits.
  - RD_END samples the end bit.
  - `Crc_error` = (received CRC ≠ computed) | (end bit ≠ 1). Error is set at the DONE entry and held until the next accepted `Send`.
- DONE: `Complete`=1 for one cycle, then IDLE. `Complete` also pulses when `Crc_error`=1.
- Counters: bit counter 5 bits (wraps 31→0 at each word boundary); word counter 8 bits; CRC counter 4 bits.

## Timing
- Reset values:
  - `Data_pin_out`=1, `Data_pin_oe`=0, `Serial_ready`=1;
  - `Complete`=0, `FIFO_read`=0, `FIFO_write`=0;
  - `Data_to_FIFO`=0, `Crc_error`=0; state IDLE.
- Write, `Send` sampled at edge k:
  - From edge k: `Serial_ready`=0, `Data_pin_oe`=1, start bit 0 on the line.
  - Word w is captured from `Data_from_FIFO` at edge k+1+32w. `FIFO_read` is high for the cycle after that edge. Its MSB is on the line in that same cycle.
  - CRC occupies cycles after edges k+1+32W … k+16+32W.
  - End bit follows edge k+17+32W.
  - `Data_pin_oe`=0 from edge k+18+32W.
  - Exactly `WORDS` `FIFO_read` pulses per block.
- Write completion: release (`Data_pin_in`=1) sampled at edge m → `Complete` high for the cycle after edge m+1; `Serial_ready`=1 from edge m+2.
- Read, start bit sampled at edge s:
  - Data bits are sampled at edges s+1 … s+32W.
  - `Data_to_FIFO` updates and `FIFO_write` pulses for one cycle after edge s+32(w+1).
  - CRC bits at edges s+32W+1 … s+32W+16; end bit at s+32W+17.
  - `Complete` and `Crc_error` are valid in the cycle after edge s+32W+18.
- Line-level: no gap between fields. `Data_pin_oe` never toggles mid-frame on write.

## Test plan
- Reset check: `Reset`=1 for 2 edges while in WR_DATA → all outputs at reset values next cycle; `Serial_ready`=1.
- Zero write, `WORDS`=1, `Data_from_FIFO`=0x00000000, `Send` 1 cycle:
  - `Data_pin_out` sequence is 0, 32×0, CRC 0x0000, 1; 50 driven cycles.
  - One `FIFO_read`.
  - With `Data_pin_in`=1, `Complete` one cycle after the 2nd busy cycle.
- Nonzero write with busy, `WORDS`=2, words 0x00000000 then 0x00000001:
  - 2 `FIFO_read` pulses 32 cycles apart; CRC on the line = 0x1021.
  - `Data_pin_in` held 0 for 10 busy cycles → no `Complete` until release, then exactly one pulse.
- Read, `WORDS`=1, `WriteRead`=0:
  - Stimulus: line 1 for 5 cycles, then 0, bits of 0x00000001, CRC 0x1021, end bit 1.
  - Required: `Data_to_FIFO`=0x00000001; one `FIFO_write`; `Complete`=1; `Crc_error`=0.
  - Repeat with CRC 0x1020 → `Crc_error`=1.
  - Repeat with end bit 0 → `Crc_error`=1.
- `Idle` asserted at the 10th write data bit:
  - Next edge: `Data_pin_oe`=0, `Data_pin_out`=1, no `Complete`, `Serial_ready`=1.
  - A following `Send` restarts cleanly; CRC 0x0000 for zero data.
- `Send` and `Idle` high simultaneously in IDLE → state stays IDLE, `Data_pin_oe` stays 0, no `FIFO_read`.
